// File: rtl/dual_cache_pkg.sv
// Shared definitions for the dual private-cache subsystem: request field
// layout, cache geometry and the per-cache controller state encoding.
package dual_cache_pkg;

    localparam int REQ_W        = 25;
    localparam int WE_BIT       = 24;
    localparam int DATA_HI      = 23;
    localparam int DATA_LO      = 16;
    localparam int ADDR_W       = 16;
    localparam int WORD_W       = 16;
    localparam int BYTE_W       = 8;

    localparam int DC_NUM_LINES = 16;
    localparam int DC_IDX_W     = $clog2(DC_NUM_LINES);
    localparam int DC_TAG_W     = ADDR_W - 1 - DC_IDX_W;

    // Line address = byte address without the offset bit; used for snooping.
    localparam int LINE_W       = ADDR_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOOKUP   = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } cache_state_e;

    // Even byte lives in the low half of a line word, odd byte in the high half.
    function automatic logic [BYTE_W-1:0] select_byte(input logic [WORD_W-1:0] word,
                                                      input logic              odd);
        return odd ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/dual_cache_top_cache_controller.sv
// One direct-mapped, write-through, write-allocate cache with 2-byte lines.
// Outputs are registered and follow the FSM state by one clock.  A peer write
// seen on the snoop input invalidates a matching line here and, if this cache
// is mid-miss on that same line, prevents the returning word from being
// installed so a stale copy can never become valid.
//
//   state       | meaning
//   ST_IDLE     | waiting for a CPU request
//   ST_LOOKUP   | tag/valid check on the captured request
//   ST_MEM_WAIT | memory request outstanding (read miss or any write)
//   ST_DONE     | result presented, waiting for CPU to drop its request
module cache_controller
    import dual_cache_pkg::*;
#(
    parameter int NUM_LINES = DC_NUM_LINES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REQ_W-1:0]  cpu_request,
    input  logic              cpu_request_ready,
    input  logic [WORD_W-1:0] memory_response,
    input  logic              memory_response_ready,
    output logic [BYTE_W-1:0] data_out,
    output logic              data_out_ready,
    output logic [REQ_W-1:0]  memory_request,
    output logic              memory_request_ready,
    input  logic              snoop_in_valid,
    input  logic [LINE_W-1:0] snoop_in_line,
    output logic              snoop_out_valid,
    output logic [LINE_W-1:0] snoop_out_line
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 1 - IDX_W;

    cache_state_e r_state;
    cache_state_e w_next_state;

    logic              r_we;
    logic [BYTE_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_addr;

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [WORD_W-1:0]    r_data [NUM_LINES];

    logic [BYTE_W-1:0] r_data_out;
    logic              r_data_out_ready;
    logic              r_mem_req_ready;
    logic              r_fill_kill;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_resp_accept;
    logic [IDX_W-1:0] w_snp_idx;
    logic [TAG_W-1:0] w_snp_tag;
    logic             w_snp_hit;
    logic             w_snp_same_line;
    logic             w_kill_fill;

    assign w_idx = r_addr[IDX_W:1];
    assign w_tag = r_addr[ADDR_W-1:IDX_W+1];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // A response only counts once the request is actually visible on the bus.
    assign w_resp_accept = (r_state == ST_MEM_WAIT) && r_mem_req_ready && memory_response_ready;

    assign w_snp_idx       = snoop_in_line[IDX_W-1:0];
    assign w_snp_tag       = snoop_in_line[LINE_W-1:IDX_W];
    assign w_snp_hit       = snoop_in_valid && r_valid[w_snp_idx] && (r_tag[w_snp_idx] == w_snp_tag);
    assign w_snp_same_line = snoop_in_valid && (snoop_in_line == r_addr[ADDR_W-1:1]);
    assign w_kill_fill     = r_fill_kill || w_snp_same_line;

    assign snoop_out_valid = (r_state == ST_MEM_WAIT) && r_we;
    assign snoop_out_line  = r_addr[ADDR_W-1:1];

    assign data_out             = r_data_out;
    assign data_out_ready       = r_data_out_ready;
    assign memory_request_ready = r_mem_req_ready;
    assign memory_request       = r_mem_req_ready
                                ? {r_we, (r_we ? r_wdata : {BYTE_W{1'b0}}), r_addr}
                                : '0;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cpu_request_ready) begin
                    w_next_state = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (!r_we && w_hit) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (w_resp_accept) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (r_data_out_ready && !cpu_request_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Capture the CPU request when leaving IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_addr  <= '0;
        end else if (r_state == ST_IDLE && cpu_request_ready) begin
            r_we    <= cpu_request[WE_BIT];
            r_wdata <= cpu_request[DATA_HI:DATA_LO];
            r_addr  <= cpu_request[ADDR_W-1:0];
        end
    end

    // Registered handshake outputs, read data and the sticky fill-suppress flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out       <= '0;
            r_data_out_ready <= 1'b0;
            r_mem_req_ready  <= 1'b0;
            r_fill_kill      <= 1'b0;
        end else begin
            r_mem_req_ready  <= (r_state == ST_MEM_WAIT) && !w_resp_accept;
            r_data_out_ready <= (r_state == ST_DONE) && (w_next_state != ST_IDLE);
            r_fill_kill      <= ((r_state == ST_LOOKUP) ||
                                 (r_state == ST_MEM_WAIT && !w_resp_accept)) && w_kill_fill;
            if (r_state == ST_LOOKUP && !r_we && w_hit) begin
                r_data_out <= select_byte(r_data[w_idx], r_addr[0]);
            end else if (w_resp_accept) begin
                r_data_out <= select_byte(memory_response, r_addr[0]);
            end
        end
    end

    // Line storage: fill on response, invalidate on a matching peer write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            if (w_resp_accept) begin
                r_data[w_idx]  <= memory_response;
                r_tag[w_idx]   <= w_tag;
                r_valid[w_idx] <= !w_kill_fill;
            end
            // A same-index fill either replaces the snooped tag or is already killed.
            if (w_snp_hit && !(w_resp_accept && w_snp_idx == w_idx)) begin
                r_valid[w_snp_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dual_cache_top.sv
// Two private caches with write-invalidate coherence: each cache's outgoing
// write address is fed to the other cache's snoop input.
module dual_cache_top
    import dual_cache_pkg::*;
#(
    parameter int NUM_LINES = DC_NUM_LINES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REQ_W-1:0]  cpu_request_0,
    input  logic              cpu_request_ready_0,
    input  logic [WORD_W-1:0] memory_response_0,
    input  logic              memory_response_ready_0,
    output logic [BYTE_W-1:0] data_out_0,
    output logic              data_out_ready_0,
    output logic [REQ_W-1:0]  memory_request_0,
    output logic              memory_request_ready_0,
    input  logic [REQ_W-1:0]  cpu_request_1,
    input  logic              cpu_request_ready_1,
    input  logic [WORD_W-1:0] memory_response_1,
    input  logic              memory_response_ready_1,
    output logic [BYTE_W-1:0] data_out_1,
    output logic              data_out_ready_1,
    output logic [REQ_W-1:0]  memory_request_1,
    output logic              memory_request_ready_1
);

    logic              w_snoop_valid_0;
    logic [LINE_W-1:0] w_snoop_line_0;
    logic              w_snoop_valid_1;
    logic [LINE_W-1:0] w_snoop_line_1;

    cache_controller #(.NUM_LINES(NUM_LINES)) u_cache_0 (
        .clock                 (clock),
        .reset                 (reset),
        .cpu_request           (cpu_request_0),
        .cpu_request_ready     (cpu_request_ready_0),
        .memory_response       (memory_response_0),
        .memory_response_ready (memory_response_ready_0),
        .data_out              (data_out_0),
        .data_out_ready        (data_out_ready_0),
        .memory_request        (memory_request_0),
        .memory_request_ready  (memory_request_ready_0),
        .snoop_in_valid        (w_snoop_valid_1),
        .snoop_in_line         (w_snoop_line_1),
        .snoop_out_valid       (w_snoop_valid_0),
        .snoop_out_line        (w_snoop_line_0)
    );

    cache_controller #(.NUM_LINES(NUM_LINES)) u_cache_1 (
        .clock                 (clock),
        .reset                 (reset),
        .cpu_request           (cpu_request_1),
        .cpu_request_ready     (cpu_request_ready_1),
        .memory_response       (memory_response_1),
        .memory_response_ready (memory_response_ready_1),
        .data_out              (data_out_1),
        .data_out_ready        (data_out_ready_1),
        .memory_request        (memory_request_1),
        .memory_request_ready  (memory_request_ready_1),
        .snoop_in_valid        (w_snoop_valid_0),
        .snoop_in_line         (w_snoop_line_0),
        .snoop_out_valid       (w_snoop_valid_1),
        .snoop_out_line        (w_snoop_line_1)
    );

endmodule

// File: tb/tb_dual_cache_top.sv
// Bench for dual_cache_top.  The reference model is a byte-addressed memory
// plus, per CPU, the line address currently held at each cache index.  Read
// data is always the newest memory byte; hit/miss follows from the model.
module tb_dual_cache_top;

    logic        clock = 1'b0;
    logic        reset;
    logic [24:0] cpu_req     [2];
    logic        cpu_rdy     [2];
    logic [15:0] mem_rsp     [2];
    logic        mem_rsp_rdy [2];
    logic [7:0]  dout        [2];
    logic        dout_rdy    [2];
    logic [24:0] mreq        [2];
    logic        mreq_rdy    [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem_b [256];
    int         held_line [2][16];

    dual_cache_top dut (
        .clock                   (clock),
        .reset                   (reset),
        .cpu_request_0           (cpu_req[0]),
        .cpu_request_ready_0     (cpu_rdy[0]),
        .memory_response_0       (mem_rsp[0]),
        .memory_response_ready_0 (mem_rsp_rdy[0]),
        .data_out_0              (dout[0]),
        .data_out_ready_0        (dout_rdy[0]),
        .memory_request_0        (mreq[0]),
        .memory_request_ready_0  (mreq_rdy[0]),
        .cpu_request_1           (cpu_req[1]),
        .cpu_request_ready_1     (cpu_rdy[1]),
        .memory_response_1       (mem_rsp[1]),
        .memory_response_ready_1 (mem_rsp_rdy[1]),
        .data_out_1              (dout[1]),
        .data_out_ready_1        (dout_rdy[1]),
        .memory_request_1        (mreq[1]),
        .memory_request_ready_1  (mreq_rdy[1])
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 16; i++)
                held_line[p][i] = -1;
    endtask

    task automatic check_outputs_zero(input int p);
        check_eq("rst_data_out", {24'd0, dout[p]}, 32'd0);
        check_eq("rst_data_out_ready", {31'd0, dout_rdy[p]}, 32'd0);
        check_eq("rst_mem_request", {7'd0, mreq[p]}, 32'd0);
        check_eq("rst_mem_request_ready", {31'd0, mreq_rdy[p]}, 32'd0);
    endtask

    // One complete CPU access on port p, with the bench acting as memory.
    task automatic do_op(input int p, input bit we, input logic [7:0] wd, input logic [15:0] a,
                         input int dly, input bit stale, input bit fill_ok, output bit used_mem);
        int          q;
        int          line;
        int          idx;
        int          base;
        int          cyc;
        bit          exp_hit;
        logic [24:0] exp_req;
        logic [15:0] word;
        logic [7:0]  exp_byte;
        q       = 1 - p;
        line    = int'(a) >> 1;
        idx     = line % 16;
        base    = line * 2;
        exp_hit = !we && (held_line[p][idx] == line);
        exp_req = {we, (we ? wd : 8'h00), a};
        used_mem = 1'b0;
        if (stale) begin
            mem_rsp[p]     = 16'h0000;
            mem_rsp_rdy[p] = 1'b1;
        end
        cpu_req[p] = {we, wd, a};
        cpu_rdy[p] = 1'b1;
        cyc = 0;
        while (cyc < 20 && !mreq_rdy[p] && !dout_rdy[p]) begin
            @(negedge clock);
            cyc++;
        end
        check_eq("first_latency", cyc, 3);
        check_eq("mem_used", {31'd0, mreq_rdy[p]}, {31'd0, !exp_hit});
        if (mreq_rdy[p]) begin
            used_mem = 1'b1;
            check_eq("mem_request", {7'd0, mreq[p]}, {7'd0, exp_req});
            mem_rsp_rdy[p] = 1'b0;
            for (int i = 0; i < dly; i++) begin
                @(negedge clock);
                check_eq("mem_hold", {6'd0, mreq_rdy[p], mreq[p]}, {6'd0, 1'b1, exp_req});
            end
            if (we) mem_b[int'(a)] = wd;
            word = {mem_b[base + 1], mem_b[base]};
            mem_rsp[p]     = word;
            mem_rsp_rdy[p] = 1'b1;
            @(negedge clock);
            mem_rsp_rdy[p] = 1'b0;
            cyc = 1;
            while (cyc < 20 && !dout_rdy[p]) begin
                @(negedge clock);
                cyc++;
            end
            check_eq("done_latency", cyc, 2);
            check_eq("mem_req_dropped", {31'd0, mreq_rdy[p]}, 32'd0);
        end
        exp_byte = mem_b[int'(a)];
        check_eq("data_out", {24'd0, dout[p]}, {24'd0, exp_byte});
        held_line[p][idx] = fill_ok ? line : -1;
        if (we && held_line[q][idx] == line) held_line[q][idx] = -1;
        cpu_rdy[p] = 1'b0;
        @(negedge clock);
        check_eq("done_clear", {31'd0, dout_rdy[p]}, 32'd0);
        check_eq("data_hold", {24'd0, dout[p]}, {24'd0, exp_byte});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        bit used;
        bit u0;
        bit u1;
        int cyc;
        for (int i = 0; i < 256; i++) mem_b[i] = (i < 64) ? 8'h00 : 8'($urandom);
        model_reset();
        reset = 1'b1;
        for (int p = 0; p < 2; p++) begin
            cpu_req[p]     = '0;
            cpu_rdy[p]     = 1'b0;
            mem_rsp[p]     = '0;
            mem_rsp_rdy[p] = 1'b0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outputs_zero(0);
        check_outputs_zero(1);
        reset = 1'b0;
        @(negedge clock);

        // Directed coherence sequence.
        do_op(0, 1, 8'd16, 16'd23, 0, 0, 1, used);
        do_op(1, 1, 8'd25, 16'd23, 1, 0, 1, used);
        do_op(0, 0, 8'd0, 16'd23, 0, 0, 1, used);
        check_eq("cpu0_read23_after_peer_write_misses", {31'd0, used}, 32'd1);
        do_op(1, 0, 8'd0, 16'd23, 0, 0, 1, used);
        check_eq("cpu1_read23_hits", {31'd0, used}, 32'd0);
        do_op(0, 0, 8'd0, 16'd23, 0, 0, 1, used);
        check_eq("cpu0_reread23_hits", {31'd0, used}, 32'd0);
        do_op(1, 1, 8'd255, 16'd34, 2, 0, 1, used);
        do_op(0, 0, 8'd0, 16'd34, 0, 0, 1, used);
        check_eq("cpu0_read34_misses", {31'd0, used}, 32'd1);
        do_op(1, 0, 8'd0, 16'd34, 0, 0, 1, used);
        check_eq("cpu1_read34_hits", {31'd0, used}, 32'd0);
        do_op(1, 1, 8'd128, 16'd34, 0, 0, 1, used);
        do_op(0, 0, 8'd0, 16'd34, 0, 0, 1, used);
        check_eq("cpu0_read34_after_rewrite_misses", {31'd0, used}, 32'd1);

        // Stale response-ready held high before a miss starts.
        mem_b[60] = 8'hA5;
        do_op(0, 0, 8'd0, 16'd60, 0, 1, 1, used);
        check_eq("stale_resp_miss", {31'd0, used}, 32'd1);

        // Peer write lands while CPU1 waits on a miss of the same line.
        fork
            do_op(1, 0, 8'd0, 16'd50, 8, 0, 0, u1);
            do_op(0, 1, 8'h5A, 16'd50, 0, 0, 1, u0);
        join
        do_op(1, 0, 8'd0, 16'd50, 0, 0, 1, used);
        check_eq("suppressed_fill_misses", {31'd0, used}, 32'd1);
        do_op(0, 0, 8'd0, 16'd50, 0, 0, 1, used);
        check_eq("writer_keeps_line", {31'd0, used}, 32'd0);

        // Randomized traffic over a small aliasing address range.
        for (int n = 0; n < 150; n++) begin
            do_op(int'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4), 8'($urandom),
                  16'($urandom_range(0, 127)), int'($urandom_range(0, 3)), 0, 1, used);
        end

        // Reset during an outstanding miss.
        do_op(0, 0, 8'd0, 16'd23, 0, 0, 1, used);
        do_op(0, 0, 8'd0, 16'd23, 0, 0, 1, used);
        check_eq("pre_reset_hit", {31'd0, used}, 32'd0);
        cpu_req[0] = {1'b0, 8'd0, 16'd200};
        cpu_rdy[0] = 1'b1;
        cyc = 0;
        while (cyc < 20 && !mreq_rdy[0]) begin
            @(negedge clock);
            cyc++;
        end
        check_eq("abort_reached_mem_wait", {31'd0, mreq_rdy[0]}, 32'd1);
        reset      = 1'b1;
        cpu_rdy[0] = 1'b0;
        @(negedge clock);
        check_outputs_zero(0);
        check_outputs_zero(1);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        check_outputs_zero(0);
        do_op(0, 0, 8'd0, 16'd23, 0, 0, 1, used);
        check_eq("post_reset_miss", {31'd0, used}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
